// File: rtl/sniff_event_packer.sv
// sniff_event_packer
// Capture front-end for the bus sniffer. It watches a sampled bus and
// timestamps every change of value. Each change is packed into a 64-bit word
// and presented to the capture FIFO through a single-entry output register.
// While the FIFO back-pressures, events that cannot be stored are counted.
// That count is later reported in-band as a marker word.
//
// Word layouts (MSB first):
//   data   : {1'b0, ts[TS_W-1:0], sample[DATA_W-1:0]}
//   marker : {1'b1, ts[TS_W-1:0], drops[DATA_W-1:0]}   (drops saturates)
module sniff_event_packer #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              fifo_full,
    output logic [63:0]       fifo_din,
    output logic              fifo_wr_en,
    output logic              busy,
    output logic [31:0]       drop_total
);
    // Timestamp fills whatever the flag bit and the sample leave of 64 bits.
    localparam int TS_W = 63 - DATA_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic [TS_W-1:0]   ts_reg;
    logic [TS_W-1:0]   ts_next;
    logic [DATA_W-1:0] sample_q_reg;
    logic [31:0]       pend_drops_reg;
    logic [31:0]       pend_drops_next;
    logic [31:0]       drop_total_reg;
    logic [31:0]       drop_total_next;
    logic [63:0]       word_reg;
    logic [63:0]       word_next;
    logic              valid_reg;
    logic              valid_next;

    logic              slot_free;
    logic              change_hit;
    logic              event_hit;
    logic              load_marker;
    logic              load_data;
    logic              drop_hit;
    logic [DATA_W-1:0] drops_field;

    // The marker's drop field is only DATA_W bits wide. A narrow field clamps
    // to all-ones, so a large count never appears as a small wrapped value. A
    // wide field holds the full 32-bit count after zero-extension.
    generate
        if (DATA_W >= 32) begin : g_drops_wide
            assign drops_field = DATA_W'(pend_drops_reg);
        end else begin : g_drops_narrow
            localparam logic [31:0] FIELD_MAX = (32'd1 << DATA_W) - 32'd1;
            assign drops_field = (pend_drops_reg > FIELD_MAX) ? {DATA_W{1'b1}}
                                                              : pend_drops_reg[DATA_W-1:0];
        end
    endgenerate

    // The output slot can take a new word if it is empty, or if the FIFO
    // accepts its current word at this edge.
    assign slot_free  = !valid_reg || !fifo_full;
    assign change_hit = (sample_in != sample_q_reg);

    // There are two kinds of event. The IDLE->RUN edge always produces an
    // initial word. In RUN, any change of the bus value produces a word.
    assign event_hit = ((state_reg == ST_IDLE) && enable) ||
                       ((state_reg == ST_RUN) && change_hit);

    // Pending drops take the slot before new data. An event that loses the
    // slot, either to a marker or to backpressure, is dropped.
    assign load_marker = slot_free && (pend_drops_reg != 32'd0);
    assign load_data   = slot_free && !load_marker && event_hit;
    assign drop_hit    = event_hit && !load_data;

    // Next-state logic. Once draining has started in FLUSH, enable has no
    // effect; FLUSH ends only when nothing is left to emit.
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_IDLE: begin
                if (enable) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (!valid_reg && (pend_drops_reg == 32'd0)) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Timestamp: held at zero while idle, and counts every cycle while active.
    // The IDLE->RUN edge stamps its word with 0 and moves the counter to 1.
    // As a result, the counter equals the number of edges since the start.
    always_comb begin
        ts_next = '0;
        if (state_next != ST_IDLE) begin
            ts_next = ts_reg + TS_W'(1);
        end
    end

    // Output slot load/hold plus pending-drop and total-drop accounting.
    always_comb begin
        word_next       = word_reg;
        valid_next      = valid_reg;
        pend_drops_next = pend_drops_reg;
        drop_total_next = drop_total_reg;

        if (load_marker) begin
            word_next  = {1'b1, ts_reg, drops_field};
            valid_next = 1'b1;
        end else if (load_data) begin
            word_next  = {1'b0, ts_reg, sample_in};
            valid_next = 1'b1;
        end else if (slot_free) begin
            valid_next = 1'b0;
        end

        // A marker reports the drops counted so far. A drop in the same cycle
        // starts the next batch at one, so it is never lost.
        if (load_marker) begin
            pend_drops_next = drop_hit ? 32'd1 : 32'd0;
        end else if (drop_hit && (pend_drops_reg != 32'hFFFF_FFFF)) begin
            pend_drops_next = pend_drops_reg + 32'd1;
        end

        if (drop_hit && (drop_total_reg != 32'hFFFF_FFFF)) begin
            drop_total_next = drop_total_reg + 32'd1;
        end
    end

    // Control state: FSM state and timestamp counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            ts_reg    <= '0;
        end else begin
            state_reg <= state_next;
            ts_reg    <= ts_next;
        end
    end

    // Datapath state: sample history, output slot and drop counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_q_reg   <= '0;
            word_reg       <= '0;
            valid_reg      <= 1'b0;
            pend_drops_reg <= '0;
            drop_total_reg <= '0;
        end else begin
            sample_q_reg   <= sample_in;
            word_reg       <= word_next;
            valid_reg      <= valid_next;
            pend_drops_reg <= pend_drops_next;
            drop_total_reg <= drop_total_next;
        end
    end

    assign fifo_din   = word_reg;
    assign fifo_wr_en = valid_reg;
    assign busy       = (state_reg != ST_IDLE);
    assign drop_total = drop_total_reg;

endmodule

// File: tb/tb_sniff_event_packer.sv
// tb_sniff_event_packer
// Self-checking bench. Expected FIFO words are queued as stimulus is driven
// and popped by a negedge monitor each time a write is accepted.
// Two instances are used: the default width and DATA_W=59, which wraps the
// timestamp quickly.
module tb_sniff_event_packer;
    localparam int DW  = 16;
    localparam int DW2 = 59;

    logic            clk = 1'b0;
    logic            rst;

    logic            enable;
    logic            fifo_full;
    logic [DW-1:0]   sample_in;
    logic [63:0]     fifo_din;
    logic            fifo_wr_en;
    logic            busy;
    logic [31:0]     drop_total;

    logic            enable2;
    logic            fifo_full2;
    logic [DW2-1:0]  sample2;
    logic [63:0]     fifo_din2;
    logic            fifo_wr_en2;
    logic            busy2;
    logic [31:0]     drop_total2;

    int              checks = 0;
    int              errors = 0;
    logic [63:0]     exp_q[$];
    logic [63:0]     exp_q2[$];
    logic [63:0]     mon_exp;
    logic [63:0]     mon_exp2;
    logic [63:0]     held;
    logic [31:0]     model_drops;

    typedef struct {
        int          gap;
        logic [15:0] sample;
        int          exp_ts;
    } vec_t;
    vec_t vecs[5];

    sniff_event_packer #(.DATA_W(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .sample_in  (sample_in),
        .fifo_full  (fifo_full),
        .fifo_din   (fifo_din),
        .fifo_wr_en (fifo_wr_en),
        .busy       (busy),
        .drop_total (drop_total)
    );

    sniff_event_packer #(.DATA_W(DW2)) dut_w (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable2),
        .sample_in  (sample2),
        .fifo_full  (fifo_full2),
        .fifo_din   (fifo_din2),
        .fifo_wr_en (fifo_wr_en2),
        .busy       (busy2),
        .drop_total (drop_total2)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        enable     = 1'b0;
        fifo_full  = 1'b0;
        sample_in  = '0;
        enable2    = 1'b0;
        fifo_full2 = 1'b0;
        sample2    = '0;
        exp_q.delete();
        exp_q2.delete();
        tick(2);
        rst = 1'b0;
        tick(1);
    endtask

    function automatic logic [63:0] dword(input logic [46:0] ts, input logic [15:0] s);
        return {1'b0, ts, s};
    endfunction

    function automatic logic [63:0] mword(input logic [46:0] ts, input logic [15:0] d);
        return {1'b1, ts, d};
    endfunction

    function automatic logic [63:0] dword2(input logic [3:0] ts, input logic [58:0] s);
        return {1'b0, ts, s};
    endfunction

    // Monitor for the default-width instance: one line for each accepted write.
    always @(negedge clk) begin
        if (!rst && fifo_wr_en && !fifo_full) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got 0x%016h expected no write", fifo_din);
            end else begin
                mon_exp = exp_q.pop_front();
                check("fifo_write", fifo_din, mon_exp);
                $display("write din=0x%016h expected=0x%016h", fifo_din, mon_exp);
            end
        end
    end

    // Monitor for the wide instance.
    always @(negedge clk) begin
        if (!rst && fifo_wr_en2 && !fifo_full2) begin
            if (exp_q2.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write_w: got 0x%016h expected no write", fifo_din2);
            end else begin
                mon_exp2 = exp_q2.pop_front();
                check("fifo_write_w", fifo_din2, mon_exp2);
                $display("write_w din=0x%016h expected=0x%016h", fifo_din2, mon_exp2);
            end
        end
    end

    initial begin
        vecs[0] = '{gap: 4, sample: 16'h1234, exp_ts: 5};
        vecs[1] = '{gap: 0, sample: 16'hBEEF, exp_ts: 6};
        vecs[2] = '{gap: 0, sample: 16'h0001, exp_ts: 7};
        vecs[3] = '{gap: 3, sample: 16'hFFFF, exp_ts: 11};
        vecs[4] = '{gap: 0, sample: 16'h0000, exp_ts: 12};

        // ---- reset state ----
        rst = 1'b1; enable = 1'b0; fifo_full = 1'b0; sample_in = '0;
        enable2 = 1'b0; fifo_full2 = 1'b0; sample2 = '0;
        tick(2);
        check("reset_wr_en", 64'(fifo_wr_en), 64'd0);
        check("reset_din", fifo_din, 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_drop_total", 64'(drop_total), 64'd0);
        rst = 1'b0;
        tick(1);

        // ---- basic capture ----
        enable = 1'b1;
        exp_q.push_back(dword(47'd0, 16'h0000));
        tick(1);                                    // edge 0
        check("run_busy", 64'(busy), 64'd1);
        for (int i = 0; i < 5; i++) begin
            tick(vecs[i].gap);
            sample_in = vecs[i].sample;
            exp_q.push_back(dword(47'(vecs[i].exp_ts), vecs[i].sample));
            tick(1);
        end
        tick(5);
        check("capture_drained", 64'(exp_q.size()), 64'd0);
        check("capture_idle_wr_en", 64'(fifo_wr_en), 64'd0);
        check("capture_drop_total", 64'(drop_total), 64'd0);
        enable = 1'b0;
        tick(3);
        check("capture_busy_low", 64'(busy), 64'd0);

        // ---- backpressure and marker ----
        do_reset();
        enable = 1'b1;
        exp_q.push_back(dword(47'd0, 16'h0000));
        tick(1);                                    // edge 0
        tick(2);                                    // edges 1..2
        sample_in = 16'h00A5;
        held = dword(47'd3, 16'h00A5);
        exp_q.push_back(held);
        tick(1);                                    // edge 3 loads
        fifo_full = 1'b1;
        for (int e = 4; e <= 13; e++) begin
            if (e == 6)       sample_in = 16'h0101;
            else if (e == 9)  sample_in = 16'h0202;
            else if (e == 11) sample_in = 16'h0303;
            tick(1);
            check("bp_held_wr_en", 64'(fifo_wr_en), 64'd1);
            check("bp_held_din", fifo_din, held);
        end
        fifo_full = 1'b0;
        exp_q.push_back(mword(47'd14, 16'd3));
        tick(2);
        check("bp_drop_total", 64'(drop_total), 64'd3);
        check("bp_drained", 64'(exp_q.size()), 64'd0);
        enable = 1'b0;
        tick(3);

        // ---- saturation ----
        do_reset();
        fifo_full = 1'b1;
        enable = 1'b1;
        exp_q.push_back(dword(47'd0, 16'h0000));
        tick(1);                                    // edge 0 loads the initial word
        model_drops = 32'd0;
        for (int k = 1; k <= 70000; k++) begin
            sample_in = ~sample_in;
            tick(1);
            if (model_drops != 32'hFFFF_FFFF) model_drops++;
        end
        check("sat_drop_total", 64'(drop_total), 64'(model_drops));
        fifo_full = 1'b0;
        exp_q.push_back(mword(47'd70001, 16'hFFFF));
        tick(2);
        check("sat_drained", 64'(exp_q.size()), 64'd0);
        enable = 1'b0;
        tick(3);

        // ---- flush ----
        do_reset();
        enable = 1'b1;
        exp_q.push_back(dword(47'd0, 16'h0000));
        tick(1);                                    // edge 0
        tick(1);                                    // edge 1 writes word 0
        sample_in = 16'h5555;
        fifo_full = 1'b1;
        held = dword(47'd2, 16'h5555);
        exp_q.push_back(held);
        tick(1);                                    // edge 2 loads
        enable = 1'b0;
        tick(1);                                    // edge 3 -> FLUSH
        for (int e = 4; e <= 7; e++) begin
            enable = (e == 5 || e == 6);
            tick(1);
            check("flush_busy", 64'(busy), 64'd1);
            check("flush_wr_en", 64'(fifo_wr_en), 64'd1);
            check("flush_din", fifo_din, held);
        end
        enable = 1'b0;
        fifo_full = 1'b0;
        tick(1);                                    // edge 8 accepts
        check("flush_busy_after_write", 64'(busy), 64'd1);
        check("flush_wr_en_after_write", 64'(fifo_wr_en), 64'd0);
        tick(1);                                    // edge 9 -> IDLE
        check("flush_busy_fall", 64'(busy), 64'd0);
        tick(4);
        check("flush_stays_idle", 64'(busy), 64'd0);
        check("flush_drained", 64'(exp_q.size()), 64'd0);

        // ---- reset mid-transfer ----
        do_reset();
        fifo_full = 1'b1;
        enable = 1'b1;
        tick(1);                                    // edge 0 loads, held
        sample_in = 16'h0F0F;
        tick(1);                                    // edge 1 drops
        check("rst_pre_wr_en", 64'(fifo_wr_en), 64'd1);
        check("rst_pre_drop_total", 64'(drop_total), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_wr_en", 64'(fifo_wr_en), 64'd0);
        check("rst_async_drop_total", 64'(drop_total), 64'd0);
        check("rst_async_din", fifo_din, 64'd0);
        check("rst_async_busy", 64'(busy), 64'd0);
        enable = 1'b0;
        fifo_full = 1'b0;
        sample_in = 16'h0000;
        #3;
        rst = 1'b0;
        tick(2);
        enable = 1'b1;
        exp_q.push_back(dword(47'd0, 16'h0000));
        tick(6);
        check("rst_no_marker", 64'(exp_q.size()), 64'd0);
        check("rst_drop_total_after", 64'(drop_total), 64'd0);
        enable = 1'b0;
        tick(3);

        // ---- timestamp wrap, DATA_W=59 ----
        do_reset();
        enable2 = 1'b1;
        exp_q2.push_back(dword2(4'd0, 59'd0));
        tick(1);                                    // edge 0
        for (int k = 1; k <= 17; k++) begin
            sample2 = 59'(k);
            exp_q2.push_back(dword2(4'(k), 59'(k)));
            tick(1);
        end
        enable2 = 1'b0;
        tick(4);
        check("wrap_drained", 64'(exp_q2.size()), 64'd0);
        check("wrap_drop_total", 64'(drop_total2), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
